// File: rtl/timer_pkg.sv
// Shared encodings and helpers for the MM:SS countdown timer controller.
package timer_pkg;

  localparam int BCD_W  = 4;
  localparam int DIGITS = 4;
  localparam int BUF_W  = BCD_W * DIGITS;

  // Encodings are visible on state_o and are relied on by the display logic.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_PAUSE = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_BKSP  = 4'hD;

  // Decimal digit key (0-9).
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  // A BCD digit may sit in the tens-of-seconds position.
  function automatic logic s10_ok(input logic [3:0] d);
    return (d <= 4'd5);
  endfunction

endpackage

// File: rtl/timer_bcd_entry_buf.sv
// Calculator-style 4-digit BCD entry buffer with digit count and S10 range check.
module bcd_entry_buf
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_en,
  input  logic [BCD_W-1:0] digit,
  input  logic             bksp_en,
  input  logic             clear_en,
  output logic [BUF_W-1:0] buf_val,
  output logic             reject
);

  logic [BUF_W-1:0] buf_r;
  logic [2:0]       cnt_r;
  logic             reject_s;

  // A digit is refused when the buffer is full or the current S1 would land in S10 out of range.
  always_comb begin
    reject_s = 1'b0;
    if (digit_en) begin
      if (cnt_r == 3'd4) begin
        reject_s = 1'b1;
      end else if (!s10_ok(buf_r[BCD_W-1:0])) begin
        reject_s = 1'b1;
      end else begin
        reject_s = 1'b0;
      end
    end else begin
      reject_s = 1'b0;
    end
  end

  // Buffer and count update: clear, shift-in, or backspace (count floors at zero).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r <= {BUF_W{1'b0}};
      cnt_r <= 3'd0;
    end else if (clear_en) begin
      buf_r <= {BUF_W{1'b0}};
      cnt_r <= 3'd0;
    end else if (digit_en && !reject_s) begin
      buf_r <= {buf_r[BUF_W-BCD_W-1:0], digit};
      cnt_r <= cnt_r + 3'd1;
    end else if (bksp_en) begin
      buf_r <= {{BCD_W{1'b0}}, buf_r[BUF_W-1:BCD_W]};
      cnt_r <= (cnt_r != 3'd0) ? (cnt_r - 3'd1) : 3'd0;
    end else begin
      buf_r <= buf_r;
      cnt_r <= cnt_r;
    end
  end

  assign buf_val = buf_r;
  assign reject  = reject_s;

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer sequencer: keypad/tick handling, FSM, buzzer timing and datapath strobes.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int BUZZ_SECS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        tick_1hz,
  input  logic        cnt_zero,
  output logic        load,
  output logic [15:0] load_val,
  output logic        dec_en,
  output logic        buzzer,
  output logic [2:0]  state_o,
  output logic        err
);

  localparam logic [7:0] BUZZ_LAST = 8'(BUZZ_SECS - 1);

  state_t           state_r, next_state_s;
  logic [7:0]       buzz_cnt_r, buzz_cnt_s;
  logic             first_run_r;
  logic             dec_s, start_err_s, err_next_s;
  logic             digit_en_s, bksp_en_s, clear_en_s, reject_s;
  logic             key_digit_s, key_start_s, key_pause_s, key_clear_s, key_bksp_s;
  logic [BUF_W-1:0] buf_val_s;
  logic             load_r, dec_r, buzzer_r, err_r;

  assign key_digit_s = key_valid && is_digit(key_code);
  assign key_start_s = key_valid && (key_code == KEY_START);
  assign key_pause_s = key_valid && (key_code == KEY_PAUSE);
  assign key_clear_s = key_valid && (key_code == KEY_CLEAR);
  assign key_bksp_s  = key_valid && (key_code == KEY_BKSP);

  bcd_entry_buf u_entry (
    .clk      (clk),
    .rst      (rst),
    .digit_en (digit_en_s),
    .digit    (key_code),
    .bksp_en  (bksp_en_s),
    .clear_en (clear_en_s),
    .buf_val  (buf_val_s),
    .reject   (reject_s)
  );

  // Next-state, buzz counter and strobe decode; in RUN cnt_zero beats keys, keys beat the tick.
  always_comb begin
    next_state_s = state_r;
    buzz_cnt_s   = buzz_cnt_r;
    dec_s        = 1'b0;
    start_err_s  = 1'b0;
    digit_en_s   = 1'b0;
    bksp_en_s    = 1'b0;
    clear_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (key_digit_s) begin
          digit_en_s = 1'b1;
        end else if (key_bksp_s) begin
          bksp_en_s = 1'b1;
        end else if (key_clear_s) begin
          clear_en_s = 1'b1;
        end else if (key_start_s) begin
          if (buf_val_s == {BUF_W{1'b0}}) begin
            start_err_s = 1'b1;
          end else begin
            next_state_s = ST_LOAD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        next_state_s = ST_RUN;
      end
      ST_RUN: begin
        // The count seen right after a load is stale, so the first RUN cycle skips it.
        if (cnt_zero && !first_run_r) begin
          next_state_s = ST_ALARM;
          buzz_cnt_s   = 8'd0;
        end else if (key_pause_s) begin
          next_state_s = ST_PAUSE;
        end else if (key_clear_s) begin
          next_state_s = ST_IDLE;
          clear_en_s   = 1'b1;
        end else if (tick_1hz) begin
          dec_s = 1'b1;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (key_start_s) begin
          next_state_s = ST_RUN;
        end else if (key_clear_s) begin
          next_state_s = ST_IDLE;
          clear_en_s   = 1'b1;
        end else begin
          next_state_s = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        // Any key silences; the buffer is kept so START replays the same time.
        if (key_valid) begin
          next_state_s = ST_IDLE;
          buzz_cnt_s   = 8'd0;
        end else if (tick_1hz) begin
          if (buzz_cnt_r == BUZZ_LAST) begin
            next_state_s = ST_IDLE;
            buzz_cnt_s   = 8'd0;
          end else begin
            buzz_cnt_s = buzz_cnt_r + 8'd1;
          end
        end else begin
          next_state_s = ST_ALARM;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        buzz_cnt_s   = 8'd0;
      end
    endcase
  end

  assign err_next_s = start_err_s | reject_s;

  // Control state registers: FSM state, buzz counter, first-RUN-cycle flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      buzz_cnt_r  <= 8'd0;
      first_run_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      buzz_cnt_r  <= buzz_cnt_s;
      first_run_r <= (state_r == ST_LOAD);
    end
  end

  // Registered output strobes; buzzer follows the ALARM state and drops on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_r   <= 1'b0;
      dec_r    <= 1'b0;
      buzzer_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      load_r   <= (next_state_s == ST_LOAD);
      dec_r    <= dec_s;
      buzzer_r <= (next_state_s == ST_ALARM);
      err_r    <= err_next_s;
    end
  end

  assign load     = load_r;
  assign load_val = buf_val_s;
  assign dec_en   = dec_r;
  assign buzzer   = buzzer_r;
  assign state_o  = state_r;
  assign err      = err_r;

endmodule
